// File: rtl/chk_seq_pkg.sv
// Shared lane state type and default parameter values for the lane sequence checker.
package chk_seq_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } lane_state_t;

    localparam int DEF_LANES      = 2;
    localparam int DEF_WORD_W     = 12;
    localparam int DEF_WORDS      = 2;
    localparam int DEF_STEP       = 16;
    localparam int DEF_LOCK_CNT   = 4;
    localparam int DEF_UNLOCK_ERR = 3;
    localparam int DEF_ERRCNT_W   = 8;

endpackage

// File: rtl/chk_seq_lane.sv
// One checked lane: predicts the next beat from the previous word 0, tracks lock
// with a HUNT/LOCKED machine and counts mismatches seen while locked.
module chk_seq_lane
    import chk_seq_pkg::*;
#(
    parameter int WORD_W     = DEF_WORD_W,
    parameter int WORDS      = DEF_WORDS,
    parameter int STEP       = DEF_STEP,
    parameter int LOCK_CNT   = DEF_LOCK_CNT,
    parameter int UNLOCK_ERR = DEF_UNLOCK_ERR,
    parameter int ERRCNT_W   = DEF_ERRCNT_W
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [WORDS*WORD_W-1:0] i_data,
    input  logic                    i_valid,
    input  logic                    i_sync,
    input  logic                    i_clr_cnt,
    output logic                    o_correct,
    output logic                    o_locked,
    output logic [ERRCNT_W-1:0]     o_err_cnt,
    output logic                    o_err_sticky
);

    localparam int RUN_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W = $clog2(UNLOCK_ERR + 1);

    lane_state_t         r_state;
    lane_state_t         w_state_nxt;
    logic [WORD_W-1:0]   r_base;
    logic                r_have_base;
    logic                w_have_base_nxt;
    logic [RUN_W-1:0]    r_run_cnt;
    logic [RUN_W-1:0]    w_run_nxt;
    logic [BAD_W-1:0]    r_bad_run;
    logic [BAD_W-1:0]    w_bad_nxt;
    logic                r_correct;
    logic [ERRCNT_W-1:0] r_err_cnt;
    logic                r_sticky;
    logic                w_match;
    logic                w_good;
    logic                w_err_evt;

    // Word k of a beat must equal base + STEP + k, wrapping modulo 2^WORD_W.
    always_comb begin : match_words
        w_match = 1'b1;
        for (int k = 0; k < WORDS; k++) begin
            if (i_data[k*WORD_W +: WORD_W] != r_base + WORD_W'(STEP + k)) begin
                w_match = 1'b0;
            end
        end
    end

    assign w_good = i_sync || !r_have_base || w_match;

    // NOTE: reset is sampled on the clock edge only, so it never appears in the sensitivity list.
    always_ff @(posedge clk) begin : state_reg
        if (!reset_n) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin : next_state
        w_state_nxt     = r_state;
        w_run_nxt       = r_run_cnt;
        w_bad_nxt       = r_bad_run;
        w_have_base_nxt = r_have_base;
        w_err_evt       = 1'b0;
        if (i_valid) begin
            w_have_base_nxt = 1'b1;
            case (r_state)
                HUNT: begin
                    // The run is judged complete on the beat that follows the last counted one.
                    if (r_run_cnt == RUN_W'(LOCK_CNT)) begin
                        w_state_nxt = LOCKED;
                        w_run_nxt   = '0;
                    end else if (w_good) begin
                        w_run_nxt = r_run_cnt + 1'b1;
                    end else begin
                        w_run_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (w_good) begin
                        w_bad_nxt = '0;
                    end else begin
                        w_err_evt = 1'b1;
                        if (r_bad_run == BAD_W'(UNLOCK_ERR - 1)) begin
                            w_state_nxt     = HUNT;
                            w_bad_nxt       = '0;
                            w_have_base_nxt = 1'b0;
                        end else begin
                            w_bad_nxt = r_bad_run + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                end
            endcase
        end
    end

    always_comb begin : state_out
        o_locked = (r_state == LOCKED);
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin : lane_regs
        if (!reset_n) begin
            r_base      <= '0;
            r_have_base <= 1'b0;
            r_run_cnt   <= '0;
            r_bad_run   <= '0;
            r_correct   <= 1'b1;
            r_err_cnt   <= '0;
            r_sticky    <= 1'b0;
        end else begin
            if (i_valid) begin
                r_base <= i_data[WORD_W-1:0];
            end
            r_have_base <= w_have_base_nxt;
            r_run_cnt   <= w_run_nxt;
            r_bad_run   <= w_bad_nxt;
            r_correct   <= !i_valid || w_good;
            // A clear in the same cycle as an error wins, so that error is dropped.
            if (i_clr_cnt) begin
                r_err_cnt <= '0;
                r_sticky  <= 1'b0;
            end else if (w_err_evt) begin
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
                r_sticky <= 1'b1;
            end
        end
    end

    assign o_correct    = r_correct;
    assign o_err_cnt    = r_err_cnt;
    assign o_err_sticky = r_sticky;

endmodule

// File: rtl/chk_seq_lanes.sv
// Multi-lane incrementing-pattern checker: LANES independent lane checkers sharing
// one counter clear, with their sticky error flags merged into one output.
module chk_seq_lanes
    import chk_seq_pkg::*;
#(
    parameter int LANES      = DEF_LANES,
    parameter int WORD_W     = DEF_WORD_W,
    parameter int WORDS      = DEF_WORDS,
    parameter int STEP       = DEF_STEP,
    parameter int LOCK_CNT   = DEF_LOCK_CNT,
    parameter int UNLOCK_ERR = DEF_UNLOCK_ERR,
    parameter int ERRCNT_W   = DEF_ERRCNT_W
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [LANES*WORDS*WORD_W-1:0] in_data,
    input  logic [LANES-1:0]              in_valid,
    input  logic [LANES-1:0]              in_sync,
    input  logic                          clr_cnt,
    output logic [LANES-1:0]              correct,
    output logic [LANES-1:0]              locked,
    output logic [LANES*ERRCNT_W-1:0]     err_cnt,
    output logic                          err_sticky
);

    localparam int LANE_W = WORDS * WORD_W;

    logic [LANES-1:0] w_sticky;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        chk_seq_lane #(
            .WORD_W     (WORD_W),
            .WORDS      (WORDS),
            .STEP       (STEP),
            .LOCK_CNT   (LOCK_CNT),
            .UNLOCK_ERR (UNLOCK_ERR),
            .ERRCNT_W   (ERRCNT_W)
        ) u_lane (
            .clk          (clk),
            .reset_n      (reset_n),
            .i_data       (in_data[l*LANE_W +: LANE_W]),
            .i_valid      (in_valid[l]),
            .i_sync       (in_sync[l]),
            .i_clr_cnt    (clr_cnt),
            .o_correct    (correct[l]),
            .o_locked     (locked[l]),
            .o_err_cnt    (err_cnt[l*ERRCNT_W +: ERRCNT_W]),
            .o_err_sticky (w_sticky[l])
        );
    end

    assign err_sticky = |w_sticky;

endmodule

// File: tb/tb_chk_seq_lanes.sv
// Self-checking bench for chk_seq_lanes: directed scenarios followed by random traffic,
// all compared every cycle against a behavioural per-lane model.
module tb_chk_seq_lanes;

    localparam int LANES      = 2;
    localparam int WORD_W     = 12;
    localparam int WORDS      = 2;
    localparam int STEP       = 16;
    localparam int LOCK_CNT   = 4;
    localparam int UNLOCK_ERR = 3;
    localparam int ERRCNT_W   = 8;
    localparam int LW         = WORDS * WORD_W;
    localparam int MASK       = (1 << WORD_W) - 1;
    localparam int ERR_MAX    = (1 << ERRCNT_W) - 1;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic [LANES*LW-1:0]       in_data;
    logic [LANES-1:0]          in_valid;
    logic [LANES-1:0]          in_sync;
    logic                      clr_cnt;
    logic [LANES-1:0]          correct;
    logic [LANES-1:0]          locked;
    logic [LANES*ERRCNT_W-1:0] err_cnt;
    logic                      err_sticky;

    int total = 0;
    int bad   = 0;

    int m_base   [LANES];
    bit m_have   [LANES];
    bit m_lock   [LANES];
    int m_run    [LANES];
    int m_bad_run[LANES];
    int m_err    [LANES];
    bit m_sticky [LANES];
    bit m_corr   [LANES];

    always #5 clk = ~clk;

    chk_seq_lanes #(
        .LANES      (LANES),
        .WORD_W     (WORD_W),
        .WORDS      (WORDS),
        .STEP       (STEP),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_ERR (UNLOCK_ERR),
        .ERRCNT_W   (ERRCNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_sync    (in_sync),
        .clr_cnt    (clr_cnt),
        .correct    (correct),
        .locked     (locked),
        .err_cnt    (err_cnt),
        .err_sticky (err_sticky)
    );

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dut_err(int l);
        return 32'(err_cnt[l*ERRCNT_W +: ERRCNT_W]);
    endfunction

    // Reference behaviour of every lane for the clock edge that just happened.
    task automatic model_clock();
        for (int l = 0; l < LANES; l++) begin
            bit good;
            bit err_evt;
            int word;
            if (!reset_n) begin
                m_base[l]    = 0;
                m_have[l]    = 1'b0;
                m_lock[l]    = 1'b0;
                m_run[l]     = 0;
                m_bad_run[l] = 0;
                m_err[l]     = 0;
                m_sticky[l]  = 1'b0;
                m_corr[l]    = 1'b1;
            end else begin
                err_evt   = 1'b0;
                m_corr[l] = 1'b1;
                if (in_valid[l]) begin
                    good = 1'b1;
                    for (int k = 0; k < WORDS; k++) begin
                        word = int'(in_data[l*LW + k*WORD_W +: WORD_W]);
                        if (word != ((m_base[l] + STEP + k) & MASK)) good = 1'b0;
                    end
                    good      = good || in_sync[l] || !m_have[l];
                    m_corr[l] = good;
                    m_have[l] = 1'b1;
                    m_base[l] = int'(in_data[l*LW +: WORD_W]);
                    if (!m_lock[l]) begin
                        if (m_run[l] == LOCK_CNT) begin
                            m_lock[l] = 1'b1;
                            m_run[l]  = 0;
                        end else begin
                            m_run[l] = good ? m_run[l] + 1 : 0;
                        end
                    end else if (good) begin
                        m_bad_run[l] = 0;
                    end else begin
                        err_evt = 1'b1;
                        m_bad_run[l]++;
                        if (m_bad_run[l] == UNLOCK_ERR) begin
                            m_lock[l]    = 1'b0;
                            m_bad_run[l] = 0;
                            m_have[l]    = 1'b0;
                        end
                    end
                end
                if (clr_cnt) begin
                    m_err[l]    = 0;
                    m_sticky[l] = 1'b0;
                end else if (err_evt) begin
                    if (m_err[l] < ERR_MAX) m_err[l]++;
                    m_sticky[l] = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        bit any_sticky;
        @(posedge clk);
        model_clock();
        #1;
        any_sticky = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            check($sformatf("correct[%0d]", l), correct[l], m_corr[l]);
            check($sformatf("locked[%0d]", l), locked[l], m_lock[l]);
            check($sformatf("err_cnt[%0d]", l), dut_err(l), m_err[l]);
            any_sticky = any_sticky | m_sticky[l];
        end
        check("err_sticky", err_sticky, any_sticky);
    endtask

    task automatic beat(int l, int w0, int w1, bit sync = 1'b0, bit clr = 1'b0);
        in_valid    = '0;
        in_sync     = '0;
        in_valid[l] = 1'b1;
        in_sync[l]  = sync;
        clr_cnt     = clr;
        in_data[l*LW +: WORD_W]          = WORD_W'(w0);
        in_data[l*LW + WORD_W +: WORD_W] = WORD_W'(w1);
        tick();
        in_valid = '0;
        in_sync  = '0;
        clr_cnt  = 1'b0;
    endtask

    initial begin
        int b;
        int w;

        // Reset while beats are presented: they must be discarded.
        reset_n  = 1'b0;
        in_valid = '1;
        in_sync  = '0;
        clr_cnt  = 1'b0;
        in_data  = {$urandom, $urandom};
        tick();
        tick();
        check("rst_correct", correct, 2'b11);
        check("rst_locked", locked, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_sticky", err_sticky, 0);
        reset_n  = 1'b1;
        in_valid = '0;
        tick();

        // Clean incrementing stream locks lane 0 after the fifth beat.
        for (int i = 0; i < 5; i++) begin
            beat(0, 'h100 + 16*i, 'h101 + 16*i);
            check("seq_correct", correct[0], 1);
            if (i == 3) check("seq_not_yet_locked", locked[0], 0);
        end
        check("seq_locked", locked[0], 1);
        check("seq_err", dut_err(0), 0);

        // Single bad beat while locked, then a beat that follows on from it.
        beat(0, 'h155, 'h156);
        check("bad1_correct", correct[0], 0);
        check("bad1_err", dut_err(0), 1);
        check("bad1_sticky", err_sticky, 1);
        check("bad1_locked", locked[0], 1);
        beat(0, 'h165, 'h166);
        check("bad1_recover", correct[0], 1);

        // Resync to 0xFF0, then the wrapped beat 0x000/0x001 must be accepted.
        beat(0, 'hFF0, 'hFF1, 1'b1);
        check("sync_correct", correct[0], 1);
        beat(0, 'h000, 'h001);
        check("wrap_correct", correct[0], 1);
        check("wrap_err", dut_err(0), 1);

        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("clr_err", dut_err(0), 0);
        check("clr_sticky", err_sticky, 0);

        // Three consecutive bad beats drop lock; the following beat has no base.
        for (int i = 0; i < 3; i++) begin
            beat(0, 'h500, 'h501);
            check("unlock_correct", correct[0], 0);
            if (i < 2) check("unlock_still_locked", locked[0], 1);
        end
        check("unlock_err", dut_err(0), 3);
        check("unlock_locked", locked[0], 0);
        beat(0, 'h777, 'h123);
        check("nobase_correct", correct[0], 1);
        check("nobase_err", dut_err(0), 3);

        // Lock lane 1 while lane 0 stays idle.
        for (int i = 0; i < 5; i++) beat(1, 'h200 + 16*i, 'h201 + 16*i);
        check("l1_locked", locked[1], 1);
        check("l0_isolated_err", dut_err(0), 3);
        check("l0_isolated_lock", locked[0], 0);

        // Bad beat on lane 1 with a same-cycle clear: the clear wins.
        beat(1, 'h999, 'h999, 1'b0, 1'b1);
        check("clrwin_correct", correct[1], 0);
        check("clrwin_err1", dut_err(1), 0);
        check("clrwin_err0", dut_err(0), 0);
        check("clrwin_sticky", err_sticky, 0);

        // A mismatching beat flagged with sync is good and not counted.
        beat(1, 'h0AA, 'h0BB, 1'b1);
        check("syncbad_correct", correct[1], 1);
        check("syncbad_err", dut_err(1), 0);

        // 300 bad beats each followed by a good one: lock held, counter saturates.
        b = 'h0AA;
        for (int i = 0; i < 300; i++) begin
            w = (b + 'h40) & MASK;
            beat(1, w, (w + 1) & MASK);
            b = w;
            w = (b + STEP) & MASK;
            beat(1, w, (w + 1) & MASK);
            b = w;
        end
        check("sat_locked", locked[1], 1);
        check("sat_err", dut_err(1), ERR_MAX);
        check("sat_sticky", err_sticky, 1);

        // Random traffic: mostly in-sequence beats with corruption, resyncs, clears and resets.
        for (int n = 0; n < 800; n++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            clr_cnt = ($urandom_range(0, 31) == 0);
            for (int l = 0; l < LANES; l++) begin
                in_valid[l] = ($urandom_range(0, 3) != 0);
                in_sync[l]  = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 3) != 0) begin
                    w = (m_base[l] + STEP) & MASK;
                    in_data[l*LW +: WORD_W] = WORD_W'(w);
                    if ($urandom_range(0, 7) == 0)
                        in_data[l*LW + WORD_W +: WORD_W] = WORD_W'($urandom);
                    else
                        in_data[l*LW + WORD_W +: WORD_W] = WORD_W'(w + 1);
                end else begin
                    in_data[l*LW +: LW] = LW'($urandom);
                end
            end
            tick();
        end

        reset_n  = 1'b1;
        in_valid = '0;
        in_sync  = '0;
        clr_cnt  = 1'b0;
        tick();
        check("final_idle_correct", correct, 2'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chk_seq_lanes.md
CHK_SEQ_LANES -- requirements
Module: chk_seq_lanes

Interface
REQ-001 Parameters SHALL be (name, default, meaning), one per line:
- LANES, 2, independent checked lanes
- WORD_W, 12, pattern word width
- WORDS, 2, words per lane per beat
- STEP, 16, base increment per beat
- LOCK_CNT, 4, consecutive good beats to lock
- UNLOCK_ERR, 3, consecutive bad beats to lose lock
- ERRCNT_W, 8, per-lane error counter width
REQ-002 Ports SHALL be (name, direction, width, meaning), one per line:
- clk, in, 1, clock
- reset_n, in, 1, synchronous, active-low reset
- in_data, in, LANES*WORDS*WORD_W, lane L at [L*WORDS*WORD_W +: WORDS*WORD_W]; word k at [k*WORD_W +: WORD_W] within the lane
- in_valid, in, LANES, per-lane beat qualifier
- in_sync, in, LANES, per-lane resynchronisation marker
- clr_cnt, in, 1, clear counters and sticky flag
- correct, out, LANES, registered per-beat check result
- locked, out, LANES, lane in LOCKED state
- err_cnt, out, LANES*ERRCNT_W, per-lane error count
- err_sticky, out, 1, any counted error since reset or clear

Function
REQ-003 Each lane SHALL hold base (WORD_W bits) and have_base (1 bit).
REQ-004 A beat SHALL be a cycle with in_valid[L]=1; non-valid cycles SHALL leave all lane state unchanged.
REQ-005 Expected word k SHALL be (base + STEP + k) mod 2^WORD_W; wrap-around is legal, e.g. base 0xFF0 with STEP 16 expects 0x000 and 0x001.
REQ-006 Beat match SHALL require all WORDS words equal to expected.
REQ-007 A beat SHALL be good if in_sync[L]=1, or have_base=0, or it matches; otherwise bad.
REQ-008 Every beat SHALL load base from word 0 and set have_base=1, whether good or bad.
REQ-009 correct[L] SHALL be registered with 1-cycle latency: the good/bad result for a beat; 1 for a non-valid cycle.
REQ-010 Lane FSM SHALL have states HUNT and LOCKED, with HUNT after reset.
REQ-011 HUNT: a good beat SHALL increment run_cnt; a bad beat SHALL zero it; when run_cnt reaches LOCK_CNT the lane SHALL go to LOCKED and zero run_cnt.
REQ-012 LOCKED: a bad beat SHALL increment bad_run; a good beat SHALL zero it; when bad_run reaches UNLOCK_ERR the lane SHALL go to HUNT and clear have_base and bad_run.
REQ-013 in_sync on a beat SHALL zero bad_run in LOCKED and count as good in HUNT.
REQ-014 in_sync without in_valid SHALL be ignored.
REQ-015 A bad beat in LOCKED SHALL increment err_cnt[L], saturating at 2^ERRCNT_W-1, and SHALL set err_sticky.
REQ-016 Bad beats in HUNT SHALL NOT count and SHALL NOT set err_sticky.
REQ-017 clr_cnt SHALL zero all err_cnt and err_sticky the next cycle; clear SHALL win over a same-cycle error, so that error is not counted.
REQ-018 clr_cnt SHALL NOT affect FSM, base, have_base or correct.
REQ-019 locked[L] SHALL be 1 in LOCKED and SHALL be registered.

Reset
REQ-020 On reset_n=0 at a clk edge, all outputs SHALL be: correct all 1, locked 0, err_cnt 0, err_sticky 0.
REQ-021 On that reset all lanes SHALL go to HUNT with base=0, have_base=0, run_cnt=0 and bad_run=0.
REQ-022 Reset mid-beat SHALL discard the beat.

Structure
REQ-023 Package chk_seq_pkg SHALL hold the lane state enum (HUNT, LOCKED) and the default parameter constants.
REQ-024 Sub-module chk_seq_lane SHALL implement one lane; the top SHALL generate LANES instances and OR their sticky flags.

Verification (LANES=2, other parameters default)
REQ-025 Lane0 sends word0 = 0x100, 0x110, 0x120, 0x130, 0x140 (word1 = word0+1) -> correct stays 1; locked[0] rises 1 cycle after the 5th beat; err_cnt 0.
REQ-026 Once locked, lane0 sends one beat 0x155/0x156 then 0x165/0x166 -> correct=0 once, err_cnt[0]=1, err_sticky=1, locked stays 1, next beat correct=1.
REQ-027 Once locked, 3 consecutive bad beats -> err_cnt=3, locked[0] falls; the next beat is good (no base), not counted.
REQ-028 Once locked, base 0xFF0 -> next beat 0x000/0x001 is correct=1 (wrap-around).
REQ-029 Bad beat on lane1 with clr_cnt=1 in the same cycle -> err_cnt[1]=0 and err_sticky=0; lane0 is unaffected by lane1 traffic.
REQ-030 Bad beat with in_sync=1 -> correct=1 and no count; then 300 bad beats interleaved with good ones keep locked and err_cnt saturates at 255.
